nn_linear_backward: RTL and testbench

Sequential backward pass of a fully-connected layer. It computes the input gradient grad_o[j] = Σ_i W[i][j]·grad_i[i], which is the transpose product of the forward linear layer, using one shared multiply-accumulate per clock. It sits behind the loss/activation-gradient stage, consumes the same weight_mat layout the forward layer uses, and feeds the previous layer's backward block.

---
 rtl/nn_linear_backward_pkg.sv | 20 ++
 rtl/nn_linear_backward_if.sv | 26 ++
 rtl/nn_linear_backward_mac.sv | 54 +++++
 rtl/nn_linear_backward.sv | 131 +++++++++++++
 tb/tb_nn_linear_backward.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_linear_backward_pkg.sv
// Shared fixed-point types for the nn_* layer blocks: Q8.8 data, Q16.16 products,
// accumulator sizing helper and the saturation bounds used when NN_SATURATE_EN is defined.
package nn_linear_backward_pkg;

  localparam int unsigned NN_DATA_W = 16;
  localparam int unsigned NN_FRAC_W = 8;
  localparam int unsigned NN_PROD_W = 2 * NN_DATA_W;

  typedef logic signed [NN_DATA_W-1:0] nn_data_t;
  typedef logic signed [NN_PROD_W-1:0] nn_prod_t;

  localparam nn_data_t NN_SAT_MAX = 16'sh7FFF;
  localparam nn_data_t NN_SAT_MIN = -16'sh8000;

  // Accumulator width for a dot product of 'rows' Q16.16 terms plus a sign guard bit
  function automatic int unsigned nn_acc_w(input int unsigned rows);
    return NN_PROD_W + $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/nn_linear_backward_if.sv
// Request/result bundle of the linear-layer backward block.
interface nn_linear_backward_if
  import nn_linear_backward_pkg::*;
#(
  parameter int unsigned IN_FEATURES  = 3,
  parameter int unsigned OUT_FEATURES = 2
);

  nn_data_t weight_mat [OUT_FEATURES][IN_FEATURES];
  nn_data_t grad_i     [OUT_FEATURES];
  logic     start;
  logic     busy;
  nn_data_t grad_o     [IN_FEATURES];
  logic     grad_v;

  modport master (
    output weight_mat, grad_i, start,
    input  busy, grad_o, grad_v
  );

  modport slave (
    input  weight_mat, grad_i, start,
    output busy, grad_o, grad_v
  );

endinterface

// File: rtl/nn_linear_backward_mac.sv
// nn_mac: shared signed multiply-accumulate with Q16.16 -> Q8.8 finalize.
// Finalize saturates when NN_SATURATE_EN is defined, otherwise wraps to 16 bits.
module nn_mac
  import nn_linear_backward_pkg::*;
#(
  parameter int unsigned ACC_W = 34
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     acc_clr,
  input  logic     acc_en,
  input  nn_data_t a,
  input  nn_data_t b,
  output nn_data_t fin_c
);

  typedef logic signed [ACC_W-1:0] acc_t;

  nn_prod_t prod_c;
  acc_t     acc;
  acc_t     sum_c;

  assign prod_c = nn_prod_t'(a) * nn_prod_t'(b);
  assign sum_c  = acc + ACC_W'(prod_c);

`ifdef NN_SATURATE_EN
  acc_t shifted_c;

  assign shifted_c = sum_c >>> NN_FRAC_W;

  // Clamp the Q8.8 result to the representable range
  always_comb begin
    fin_c = shifted_c[NN_DATA_W-1:0];
    if (shifted_c > acc_t'(NN_SAT_MAX)) begin
      fin_c = NN_SAT_MAX;
    end else if (shifted_c < acc_t'(NN_SAT_MIN)) begin
      fin_c = NN_SAT_MIN;
    end
  end
`else
  // Floor shift then keep the low 16 bits (two's-complement wrap)
  assign fin_c = sum_c[NN_FRAC_W +: NN_DATA_W];
`endif

  // Running sum; clear wins over accumulate
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/nn_linear_backward.sv
// nn_linear_backward: grad_o[j] = sum_i W[i][j] * grad_i[i], one MAC per clock.
// Optional build macro: NN_SATURATE_EN (saturating finalize instead of wrap).
module nn_linear_backward
  import nn_linear_backward_pkg::*;
#(
  parameter int unsigned IN_FEATURES  = 3,
  parameter int unsigned OUT_FEATURES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nn_linear_backward_if.slave  bus
);

  localparam int unsigned ROW_W = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;
  localparam int unsigned COL_W = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int unsigned ACC_W = nn_acc_w(OUT_FEATURES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  nn_data_t         grad_q  [OUT_FEATURES];
  nn_data_t         col_buf [IN_FEATURES];

  logic     accept_c;
  logic     mac_c;
  logic     col_done_c;
  logic     last_c;
  logic     acc_clr_c;
  logic     next_busy_c;
  logic     next_grad_v_c;
  nn_data_t mul_w_c;
  nn_data_t mul_g_c;
  nn_data_t fin_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and step decode
  always_comb begin
    next_state    = state;
    accept_c      = 1'b0;
    mac_c         = 1'b0;
    col_done_c    = 1'b0;
    last_c        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept_c   = 1'b1;
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        mac_c = 1'b1;
        if (row == ROW_W'(OUT_FEATURES - 1)) begin
          col_done_c = 1'b1;
          if (col == COL_W'(IN_FEATURES - 1)) begin
            last_c     = 1'b1;
            next_state = S_DONE;
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    acc_clr_c     = accept_c | col_done_c;
    next_busy_c   = (next_state != S_IDLE);
    next_grad_v_c = (next_state == S_DONE);
  end

  assign mul_w_c = bus.weight_mat[row][col];
  assign mul_g_c = grad_q[row];

  nn_mac #(.ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst     (rst_n),
    .acc_clr (acc_clr_c),
    .acc_en  (mac_c),
    .a       (mul_w_c),
    .b       (mul_g_c),
    .fin_c   (fin_c)
  );

  // Counters, latched gradient, column buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      row        <= '0;
      col        <= '0;
      bus.busy   <= 1'b0;
      bus.grad_v <= 1'b0;
      for (int unsigned k = 0; k < OUT_FEATURES; k++) grad_q[k] <= '0;
      for (int unsigned k = 0; k < IN_FEATURES; k++) begin
        col_buf[k]    <= '0;
        bus.grad_o[k] <= '0;
      end
    end else begin
      bus.busy   <= next_busy_c;
      bus.grad_v <= next_grad_v_c;
      if (accept_c) begin
        row <= '0;
        col <= '0;
        for (int unsigned k = 0; k < OUT_FEATURES; k++) grad_q[k] <= bus.grad_i[k];
      end
      if (mac_c) begin
        if (col_done_c) begin
          row          <= '0;
          col          <= last_c ? '0 : col + COL_W'(1);
          col_buf[col] <= fin_c;
          if (last_c) begin
            for (int unsigned k = 0; k < IN_FEATURES; k++) begin
              bus.grad_o[k] <= (k == IN_FEATURES - 1) ? fin_c : col_buf[k];
            end
          end
        end else begin
          row <= row + ROW_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_linear_backward.sv
// Self-checking bench for nn_linear_backward (3x2 defaults); expected result vectors
// are queued when an operation is started and checked whenever grad_v pulses.
module tb_nn_linear_backward;
  import nn_linear_backward_pkg::*;

  localparam int unsigned IN  = 3;
  localparam int unsigned OUT = 2;

  typedef nn_data_t [IN-1:0] vec_t;

  logic clk;
  logic rst_n;
  logic rst_at_edge;

  int n_checks = 0;
  int n_fail   = 0;
  int n_gv     = 0;

  nn_data_t w_tb [OUT][IN];
  nn_data_t g_tb [OUT];
  vec_t     exp_q [$];
  vec_t     mon_cur;
  vec_t     mon_last;
  vec_t     mon_exp;

  nn_linear_backward_if #(.IN_FEATURES(IN), .OUT_FEATURES(OUT)) bus ();

  nn_linear_backward #(.IN_FEATURES(IN), .OUT_FEATURES(OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge <= rst_n;

  function automatic vec_t pack_o();
    vec_t v;
    for (int k = 0; k < IN; k++) v[k] = bus.grad_o[k];
    return v;
  endfunction

  // Reference: exact integer dot product, floor shift, then saturate or wrap
  function automatic vec_t model();
    vec_t v;
    for (int j = 0; j < IN; j++) begin
      longint s = 0;
      for (int i = 0; i < OUT; i++) s += longint'(w_tb[i][j]) * longint'(g_tb[i]);
      s = s >>> 8;
`ifdef NN_SATURATE_EN
      if (s > 32767) v[j] = 16'h7FFF;
      else if (s < -32768) v[j] = 16'h8000;
      else v[j] = s[15:0];
`else
      v[j] = s[15:0];
`endif
    end
    return v;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < OUT; i++) begin
      bus.grad_i[i] = g_tb[i];
      for (int j = 0; j < IN; j++) bus.weight_mat[i][j] = w_tb[i][j];
    end
  endtask

  task automatic set_w_all(input nn_data_t v);
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < IN; j++) w_tb[i][j] = v;
  endtask

  task automatic set_basic();
    w_tb[0][0] = 16'h0100; w_tb[0][1] = 16'h0200; w_tb[0][2] = 16'h0300;
    w_tb[1][0] = 16'h0400; w_tb[1][1] = 16'h0500; w_tb[1][2] = 16'h0600;
    g_tb[0] = 16'h0100; g_tb[1] = 16'h0080;
    apply_inputs();
  endtask

  // Result checker and grad_o stability watch, sampled on the falling edge
  always @(negedge clk) begin
    mon_cur = pack_o();
    if (rst_at_edge !== 1'b0) begin
      mon_last = mon_cur;
    end else begin
      n_checks++;
      if (bus.grad_v === 1'b1) begin
        n_gv++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL grad_v_unexpected: grad_v=1 with no operation pending, grad_o=%h", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            n_fail++;
            $display("FAIL result: grad_o=%h expected %h", mon_cur, mon_exp);
          end
        end
      end else if (mon_cur !== mon_last) begin
        n_fail++;
        $display("FAIL grad_o_stable: grad_o=%h changed without grad_v, expected %h", mon_cur, mon_last);
      end
      mon_last = mon_cur;
    end
  end

  task automatic chk_ctl(input string name, input logic exp_busy, input logic exp_gv);
    n_checks++;
    if (bus.busy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s busy: got %b expected %b", name, bus.busy, exp_busy);
    end
    n_checks++;
    if (bus.grad_v !== exp_gv) begin
      n_fail++;
      $display("FAIL %s grad_v: got %b expected %b", name, bus.grad_v, exp_gv);
    end
  endtask

  // Starts one operation from the current cycle and checks its 8-cycle timeline
  task automatic run_op(input vec_t expv, input string name);
    bus.start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk_ctl(name, (k <= 7), (k == 7));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("reset", 1'b0, 1'b0);
    n_checks++;
    if (pack_o() !== vec_t'(0)) begin
      n_fail++;
      $display("FAIL reset grad_o: got %h expected 0", pack_o());
    end
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk_ctl("reset_start_dropped", 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    set_basic();
    run_op({16'h0600, 16'h0480, 16'h0300}, "basic");
  endtask

  task automatic test_saturation();
    set_w_all(16'h7F00);
    g_tb[0] = 16'h7F00; g_tb[1] = 16'h7F00;
    apply_inputs();
`ifdef NN_SATURATE_EN
    run_op({3{16'h7FFF}}, "sat_pos");
`else
    run_op({3{16'h0200}}, "wrap_pos");
`endif
    set_w_all(16'h8100);
    apply_inputs();
`ifdef NN_SATURATE_EN
    run_op({3{16'h8000}}, "sat_neg");
`else
    run_op({3{16'hFE00}}, "wrap_neg");
`endif
  endtask

  task automatic test_truncation();
    set_w_all(16'h0000);
    w_tb[0][0] = 16'h0001;
    g_tb[0] = 16'h0080; g_tb[1] = 16'h0000;
    apply_inputs();
    run_op({16'h0000, 16'h0000, 16'h0000}, "trunc_pos");
    w_tb[0][0] = 16'hFFFF;
    apply_inputs();
    run_op({16'h0000, 16'h0000, 16'hFFFF}, "trunc_neg");
    w_tb[0][0] = 16'hFF00;
    g_tb[0] = 16'h0100;
    apply_inputs();
    run_op({16'h0000, 16'h0000, 16'hFF00}, "sign_neg_one");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < OUT; i++) begin
        g_tb[i] = 16'($urandom());
        for (int j = 0; j < IN; j++) w_tb[i][j] = 16'($urandom());
      end
      apply_inputs();
      run_op(model(), "random");
    end
  endtask

  task automatic test_start_while_busy();
    int gv0;
    set_basic();
    gv0 = n_gv;
    bus.start = 1'b1;
    exp_q.push_back({16'h0600, 16'h0480, 16'h0300});
    @(posedge clk); #1;
    bus.grad_i[0] = 16'h7F00;
    bus.grad_i[1] = 16'h7F00;
    for (int k = 1; k <= 8; k++) begin
      bus.start = (k == 3 || k == 7);
      chk_ctl("busy_start", (k <= 7), (k == 7));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (4) begin
      chk_ctl("busy_start_idle", 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_gv - gv0 !== 1) begin
      n_fail++;
      $display("FAIL busy_start pulses: got %0d grad_v pulses expected 1", n_gv - gv0);
    end
  endtask

  task automatic test_reset_mid_op();
    set_basic();
    bus.start = 1'b1;
    exp_q.push_back({16'h0600, 16'h0480, 16'h0300});
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_ctl("reset_mid_pre", 1'b1, 1'b0);
      if (k == 4) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    chk_ctl("reset_mid", 1'b0, 1'b0);
    n_checks++;
    if (pack_o() !== vec_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid grad_o: got %h expected 0", pack_o());
    end
    repeat (10) begin
      @(posedge clk); #1;
      chk_ctl("reset_mid_quiet", 1'b0, 1'b0);
    end
    run_op({16'h0600, 16'h0480, 16'h0300}, "after_reset");
  endtask

  task automatic test_back_to_back();
    localparam int N = 3;
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < IN; j++) w_tb[i][j] = 16'($urandom_range(0, 2047)) - 16'sd1024;
    g_tb[0] = 16'h0180; g_tb[1] = 16'hFE40;
    apply_inputs();
    exp_q.push_back(model());
    bus.start = 1'b1;
    for (int c = 1; c <= 8 * N; c++) begin
      @(posedge clk); #1;
      if ((c - 1) % 8 == 0) begin
        if ((c - 1) / 8 < N - 1) begin
          g_tb[0] = 16'($urandom_range(0, 4095)) - 16'sd2048;
          g_tb[1] = 16'($urandom_range(0, 4095)) - 16'sd2048;
          apply_inputs();
          exp_q.push_back(model());
        end else begin
          bus.start = 1'b0;
        end
      end
      chk_ctl("back_to_back", (c % 8 != 0), (c % 8 == 7));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0;
    set_w_all(16'h0000);
    g_tb[0] = 16'h0000; g_tb[1] = 16'h0000;
    apply_inputs();

    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_random();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d results never produced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
